// File: rtl/mpu6050_pkg.sv
// Shared MPU6050 definitions: register addresses, the I2C responder state
// enum and the default target address. The gyro driver imports this package
// too, so both sides agree on one register map.
package mpu6050_pkg;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h68;

  localparam logic [7:0] REG_CONFIG      = 8'd26;   // DLPF configuration
  localparam logic [7:0] REG_GYRO_CONFIG = 8'd27;
  localparam logic [7:0] REG_INT_PIN_CFG = 8'd55;
  localparam logic [7:0] REG_INT_ENABLE  = 8'd56;
  localparam logic [7:0] REG_INT_STATUS  = 8'd58;
  localparam logic [7:0] REG_GYRO_XOUT_H = 8'd67;   // 67..72: X/Y/Z, high byte first
  localparam logic [7:0] REG_PWR_MGMT_1  = 8'd107;
  localparam logic [7:0] REG_WHO_AM_I    = 8'd117;

  localparam logic [7:0] PWR_MGMT_1_RST  = 8'h40;   // device comes up asleep

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_MACK,
    ST_WAIT_STOP
  } resp_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the asynchronous SCL/SDA bus levels into the clk domain and derives
// the bus events the responder acts on.
//   clk, rst        system clock, synchronous active-high reset
//   scl_i, sda_i    raw bus levels
//   scl, sda        synchronized levels
//   scl_rise/fall   one-cycle pulses on synchronized SCL edges
//   start_det       SDA fell while SCL stayed high
//   stop_det        SDA rose while SCL stayed high
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value, which is what makes the 2-flop chain work.
  always_ff @(posedge clk) begin
    if (rst) begin
      // An idle bus sits high; resetting to 1 avoids a phantom edge.
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  =  scl & ~scl_prev;
  assign scl_fall  = ~scl &  scl_prev;
  // SCL must be high on both sides of the SDA edge to count as START/STOP.
  assign start_det = scl & scl_prev &  sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev &  sda;

endmodule

// File: rtl/mpu6050_i2c_responder.sv
// I2C target emulating the MPU6050 registers used by the gyro driver.
// Stores host configuration writes and serves burst reads of the gyro
// sample, which is frozen into a snapshot at the start of each read.
//   clk, rst                    system clock (>= 8x SCL), sync active-high reset
//   scl_i, sda_i                bus levels; scl_o/sda_o open-drain drives (1 = release)
//   gyro_x/y/z, sample_strobe   current sample and its new-data pulse
//   pwr_mgmt_1 .. int_pin_cfg   stored R/W register contents
//   wr_valid, wr_addr, wr_data  one pulse per accepted data byte
//   busy                        address-matched transaction in progress
module mpu6050_i2c_responder
  import mpu6050_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR   = DEFAULT_SLAVE_ADDR,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               scl_o,
  output logic               sda_o,
  input  logic signed [15:0] gyro_x,
  input  logic signed [15:0] gyro_y,
  input  logic signed [15:0] gyro_z,
  input  logic               sample_strobe,
  output logic [7:0]         pwr_mgmt_1,
  output logic [7:0]         gyro_config,
  output logic [7:0]         dlpf_config,
  output logic [7:0]         int_enable,
  output logic [7:0]         int_pin_cfg,
  output logic               wr_valid,
  output logic [7:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy
);

  logic scl_unused;   // START/STOP qualification already lives in the sync
  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl       (scl_unused),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // No clock stretching: the responder always keeps up at >= 8x SCL.
  assign scl_o = 1'b1;

  resp_state_t state;
  logic [7:0]  ptr;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        ack_phase;   // 0: waiting for 8th fall, 1: ACK driven, waiting for 9th
  logic        rw;
  logic        mack_ok;     // host ACKed the byte just sent
  logic        int_status;
  logic [47:0] snapshot;    // {x, y, z} frozen for one read burst
  logic [7:0]  rd_byte;
  logic        int_clr;

  // Byte served for the current pointer.
  // NOTE: always_comb gets a default first so no path leaves rd_byte
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      REG_GYRO_XOUT_H:         rd_byte = snapshot[47:40];
      REG_GYRO_XOUT_H + 8'd1:  rd_byte = snapshot[39:32];
      REG_GYRO_XOUT_H + 8'd2:  rd_byte = snapshot[31:24];
      REG_GYRO_XOUT_H + 8'd3:  rd_byte = snapshot[23:16];
      REG_GYRO_XOUT_H + 8'd4:  rd_byte = snapshot[15:8];
      REG_GYRO_XOUT_H + 8'd5:  rd_byte = snapshot[7:0];
      REG_INT_STATUS:          rd_byte = {7'b0, int_status};
      REG_WHO_AM_I:            rd_byte = WHO_AM_I_VAL;
      REG_CONFIG:              rd_byte = dlpf_config;
      REG_GYRO_CONFIG:         rd_byte = gyro_config;
      REG_INT_PIN_CFG:         rd_byte = int_pin_cfg;
      REG_INT_ENABLE:          rd_byte = int_enable;
      REG_PWR_MGMT_1:          rd_byte = pwr_mgmt_1;
      default:                 rd_byte = 8'h00;
    endcase
  end

  // A data byte has been fully shifted out on the fall that releases SDA.
  assign int_clr = (state == ST_RDATA) && scl_fall && (bit_cnt == 3'd7) &&
                   ((ptr == REG_INT_STATUS) || int_pin_cfg[4]);

  always_ff @(posedge clk) begin
    if (rst) begin
      int_status <= 1'b0;
    end else if (sample_strobe) begin
      int_status <= 1'b1;       // set wins over a same-cycle clear
    end else if (int_clr) begin
      int_status <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sda_o       <= 1'b1;
      busy        <= 1'b0;
      ptr         <= 8'h00;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      ack_phase   <= 1'b0;
      rw          <= 1'b0;
      mack_ok     <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      snapshot    <= 48'h0;
      pwr_mgmt_1  <= PWR_MGMT_1_RST;
      gyro_config <= 8'h00;
      dlpf_config <= 8'h00;
      int_enable  <= 8'h00;
      int_pin_cfg <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        // Covers repeated START too; the pointer is kept for write-ptr/Sr/read.
        state     <= ST_ADDR;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
        sda_o     <= 1'b1;
      end else if (stop_det) begin
        state <= ST_IDLE;
        sda_o <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;

          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == ST_ADDR) begin
                  if (shreg[6:0] == SLAVE_ADDR) begin
                    state <= ST_ADDR_ACK;
                    rw    <= sda;
                    busy  <= 1'b1;
                    if (sda) snapshot <= {gyro_x, gyro_y, gyro_z};
                  end else begin
                    state <= ST_WAIT_STOP;
                    busy  <= 1'b0;
                  end
                end else if (state == ST_PTR) begin
                  ptr   <= {shreg[6:0], sda};
                  state <= ST_PTR_ACK;
                end else begin
                  state <= ST_WDATA_ACK;
                end
              end
            end
          end

          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_o     <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                if (state == ST_ADDR_ACK && rw) begin
                  // First read bit goes out on the fall that ends the ACK.
                  shreg <= rd_byte;
                  sda_o <= rd_byte[7];
                  state <= ST_RDATA;
                end else begin
                  sda_o <= 1'b1;
                  state <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                  if (state == ST_WDATA_ACK) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= ptr;
                    wr_data  <= shreg;
                    ptr      <= ptr + 8'd1;
                    case (ptr)
                      REG_CONFIG:      dlpf_config <= shreg;
                      REG_GYRO_CONFIG: gyro_config <= shreg;
                      REG_INT_PIN_CFG: int_pin_cfg <= shreg;
                      REG_INT_ENABLE:  int_enable  <= shreg;
                      REG_PWR_MGMT_1:  pwr_mgmt_1  <= shreg;
                      default: ;
                    endcase
                  end
                end
              end
            end
          end

          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_o   <= 1'b1;
                ptr     <= ptr + 8'd1;
                mack_ok <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= ST_RDATA_MACK;
              end else begin
                sda_o   <= shreg[6];
                shreg   <= {shreg[6:0], 1'b1};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          ST_RDATA_MACK: begin
            if (scl_rise) begin
              if (sda) begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end else begin
                mack_ok <= 1'b1;
              end
            end else if (scl_fall && mack_ok) begin
              mack_ok <= 1'b0;
              shreg   <= rd_byte;
              sda_o   <= rd_byte[7];
              state   <= ST_RDATA;
            end
          end

          ST_WAIT_STOP: sda_o <= 1'b1;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu6050_i2c_responder.sv
module tb_mpu6050_i2c_responder;

  localparam int Q = 5;   // clk cycles per quarter SCL period

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               scl_m = 1'b1;
  logic               sda_m = 1'b1;
  logic               scl_o;
  logic               sda_o;
  logic signed [15:0] gyro_x = '0;
  logic signed [15:0] gyro_y = '0;
  logic signed [15:0] gyro_z = '0;
  logic               sample_strobe = 1'b0;
  logic [7:0]         pwr_mgmt_1, gyro_config, dlpf_config, int_enable, int_pin_cfg;
  logic               wr_valid;
  logic [7:0]         wr_addr, wr_data;
  logic               busy;

  wire scl_bus = scl_m & scl_o;
  wire sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  mpu6050_i2c_responder dut (
    .clk           (clk),
    .rst           (rst),
    .scl_i         (scl_bus),
    .sda_i         (sda_bus),
    .scl_o         (scl_o),
    .sda_o         (sda_o),
    .gyro_x        (gyro_x),
    .gyro_y        (gyro_y),
    .gyro_z        (gyro_z),
    .sample_strobe (sample_strobe),
    .pwr_mgmt_1    (pwr_mgmt_1),
    .gyro_config   (gyro_config),
    .dlpf_config   (dlpf_config),
    .int_enable    (int_enable),
    .int_pin_cfg   (int_pin_cfg),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] wr_log[$];
  logic        ack_bits[0:3];
  logic        busy_mid;
  logic        sda_after_nack;
  logic [7:0]  rd_buf[0:5];
  logic [15:0] mid_x, mid_y, mid_z;

  always @(negedge clk) if (wr_valid) wr_log.push_back({wr_addr, wr_data});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic pulse_strobe(input logic [15:0] x, y, z);
    gyro_x = x; gyro_y = y; gyro_z = z;
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack, input logic strobe_mid);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
      if (strobe_mid && i == 5) pulse_strobe(mid_x, mid_y, mid_z);
    end
    write_bit(nack);
  endtask

  task automatic i2c_write(input logic [7:0] addr_byte, input logic [7:0] r,
                           input logic [7:0] d0, input logic [7:0] d1, input int nd);
    for (int i = 0; i < 4; i++) ack_bits[i] = 1'b1;
    bus_start();
    write_byte(addr_byte, ack_bits[0]);
    busy_mid = busy;
    write_byte(r, ack_bits[1]);
    if (nd > 0) write_byte(d0, ack_bits[2]);
    if (nd > 1) write_byte(d1, ack_bits[3]);
    bus_stop();
  endtask

  // Write pointer, repeated START, read n bytes; strobe mid-byte strobe_at.
  task automatic read_regs(input logic [7:0] r, input int n, input int strobe_at);
    logic [7:0] d;
    logic       a0, a1, a2;
    bus_start();
    write_byte(8'hD0, a0);
    write_byte(r, a1);
    bus_start();
    write_byte(8'hD1, a2);
    ack_bits[0] = a0 | a1 | a2;
    for (int k = 0; k < n; k++) begin
      read_byte(d, (k == n - 1), (k == strobe_at));
      rd_buf[k] = d;
    end
    sda_after_nack = sda_o;
    bus_stop();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_sda_o", sda_o, 1'b1);
    check("rst_scl_o", scl_o, 1'b1);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pwr_mgmt_1", pwr_mgmt_1, 8'h40);
    check("rst_cfg_regs", {gyro_config, dlpf_config, int_enable, int_pin_cfg}, 32'h0);

    // 1: single register write
    i2c_write(8'hD0, 8'd27, 8'h10, 8'h00, 1);
    check("t1_acks", {ack_bits[0], ack_bits[1], ack_bits[2]}, 3'b000);
    check("t1_busy_mid", busy_mid, 1'b1);
    check("t1_busy_after_stop", busy, 1'b0);
    check("t1_gyro_config", gyro_config, 8'h10);
    check("t1_wr_count", wr_log.size(), 1);
    check("t1_wr_entry", wr_log[0], 16'h1B10);

    // 2: pointer write, Sr, 6-byte burst
    gyro_x = 16'h1234; gyro_y = 16'hFF80; gyro_z = 16'h0001;
    read_regs(8'd67, 6, -1);
    check("t2_acks", ack_bits[0], 1'b0);
    check("t2_bytes", {rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3], rd_buf[4], rd_buf[5]},
          48'h1234FF800001);
    check("t2_sda_released", sda_after_nack, 1'b1);

    // 3: wrong address is ignored
    i2c_write(8'hD2, 8'd27, 8'h55, 8'h00, 1);
    check("t3_addr_nack", ack_bits[0], 1'b1);
    check("t3_data_nack", ack_bits[2], 1'b1);
    check("t3_busy", busy_mid, 1'b0);
    check("t3_gyro_config", gyro_config, 8'h10);
    check("t3_wr_count", wr_log.size(), 1);

    // 4: snapshot coherence and INT_STATUS
    pulse_strobe(16'h8001, 16'h7FFE, 16'hC3A5);
    mid_x = 16'h0102; mid_y = 16'h0304; mid_z = 16'h0506;
    read_regs(8'd67, 6, 2);
    check("t4_old_burst", {rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3], rd_buf[4], rd_buf[5]},
          48'h80017FFEC3A5);
    read_regs(8'd67, 6, -1);
    check("t4_new_burst", {rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3], rd_buf[4], rd_buf[5]},
          48'h010203040506);
    read_regs(8'd58, 1, -1);
    check("t4_int_status_set", rd_buf[0], 8'h01);
    read_regs(8'd58, 1, -1);
    check("t4_int_status_clr", rd_buf[0], 8'h00);

    // 5: pointer wrap from 255
    i2c_write(8'hD0, 8'd255, 8'hAB, 8'hCD, 2);
    check("t5_acks", {ack_bits[0], ack_bits[1], ack_bits[2], ack_bits[3]}, 4'b0000);
    check("t5_wr_count", wr_log.size(), 3);
    check("t5_wr_255", wr_log[1], 16'hFFAB);
    check("t5_wr_0", wr_log[2], 16'h00CD);
    check("t5_regs_kept", {pwr_mgmt_1, gyro_config, dlpf_config, int_enable, int_pin_cfg},
          40'h4010000000);

    // int_pin_cfg[4]: any data read clears INT_STATUS
    i2c_write(8'hD0, 8'd55, 8'h10, 8'h00, 1);
    check("t5b_int_pin_cfg", int_pin_cfg, 8'h10);
    pulse_strobe(16'h0102, 16'h0304, 16'h0506);
    read_regs(8'd67, 1, -1);
    check("t5b_gyro_xh", rd_buf[0], 8'h01);
    read_regs(8'd58, 1, -1);
    check("t5b_int_any_clr", rd_buf[0], 8'h00);

    // 6: reset while driving ACK
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'hD0 >> i) & 8'h01) != 0);
    repeat (4) @(negedge clk);
    check("t6_ack_driven", sda_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_release", sda_o, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_regs_reset", {pwr_mgmt_1, gyro_config, int_pin_cfg, busy}, 25'h80_0000 | (25'h40 << 17));
    read_regs(8'd117, 1, -1);
    check("t6_who_am_i", rd_buf[0], 8'h68);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
